i2c_bus_arbiter: RTL and testbench

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

---
 rtl/i2c_bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one I2C master between two requesters (A: fan/temperature loop,
// B: power monitor) with round-robin arbitration and one transaction at a time.
//
// Ports
//   OSC_50            system clock, rising edge
//   RESET_N           synchronous active-low reset
//   REQ_A / REQ_B     level transaction requests
//   CMD_A / CMD_B     commands {WR, DEV[6:0], REG[7:0], WDATA[15:0]}
//   GNT_A / GNT_B     requester owns the bus (grant through FINISH)
//   DONE_A / DONE_B   one-cycle completion strobe
//   RDATA, ERR        read data / error of the last completed transaction
//   M_START, M_CMD    start strobe and latched command to the master
//   M_BUSY, M_DONE    master status and completion strobe
//   M_RDATA, M_NACK   master results, valid with M_DONE
//
// Configuration
//   I2C_ARB_WDOG_EN   when defined, a watchdog aborts a transaction after
//                     WDOG_CYCLES cycles with ERR=1 and RDATA=16'hFFFF.
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
   parameter int unsigned WDOG_CYCLES = 2500000
) (
   input  logic        OSC_50,
   input  logic        RESET_N,
   input  logic        REQ_A,
   input  logic [31:0] CMD_A,
   input  logic        REQ_B,
   input  logic [31:0] CMD_B,
   output logic        GNT_A,
   output logic        GNT_B,
   output logic        DONE_A,
   output logic        DONE_B,
   output logic [15:0] RDATA,
   output logic        ERR,
   output logic        M_START,
   output logic [31:0] M_CMD,
   input  logic        M_BUSY,
   input  logic        M_DONE,
   input  logic [15:0] M_RDATA,
   input  logic        M_NACK
);

   localparam int unsigned CMD_W  = 32;
   localparam int unsigned DATA_W = 16;

   // The watchdog compare needs at least two cycles of WAIT headroom.
   if (WDOG_CYCLES < 2) begin : g_wdog_range
      $error("WDOG_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_FINISH
   } state_t;

   state_t              state_q, state_d;
   logic                gnt_a_q, gnt_a_d;
   logic                gnt_b_q, gnt_b_d;
   logic                done_a_q, done_a_d;
   logic                done_b_q, done_b_d;
   logic                m_start_q, m_start_d;
   logic [CMD_W-1:0]    m_cmd_q, m_cmd_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                last_b_q, last_b_d;   // 1: B won the last arbitration
   logic                pick_b_c;

`ifdef I2C_ARB_WDOG_EN
   localparam int unsigned WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic [WDOG_W-1:0]   wdog_inc_c;
`endif

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      gnt_a_d   = gnt_a_q;
      gnt_b_d   = gnt_b_q;
      done_a_d  = 1'b0;
      done_b_d  = 1'b0;
      m_start_d = 1'b0;
      m_cmd_d   = m_cmd_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      last_b_d  = last_b_q;
      // B wins when it is alone, or when both request and A won last time
      pick_b_c  = REQ_B && (!REQ_A || !last_b_q);
`ifdef I2C_ARB_WDOG_EN
      wdog_d     = wdog_q;
      wdog_inc_c = wdog_q + 1'b1;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (REQ_A || REQ_B) begin
               state_d   = ST_ISSUE;
               gnt_a_d   = !pick_b_c;
               gnt_b_d   = pick_b_c;
               last_b_d  = pick_b_c;
               m_cmd_d   = pick_b_c ? CMD_B : CMD_A;
               m_start_d = !M_BUSY;
            end
         end

         // Stay here until a start has actually been presented to an idle master
         ST_ISSUE: begin
`ifdef I2C_ARB_WDOG_EN
            wdog_d = '0;
`endif
            if (m_start_q) begin
               state_d = ST_WAIT;
            end else begin
               m_start_d = !M_BUSY;
            end
         end

         ST_WAIT: begin
            if (M_DONE) begin
               state_d  = ST_FINISH;
               rdata_d  = M_RDATA;
               err_d    = M_NACK;
               done_a_d = gnt_a_q;
               done_b_d = gnt_b_q;
            end
`ifdef I2C_ARB_WDOG_EN
            else begin
               wdog_d = wdog_inc_c;
               // Abort when the count reaches WDOG_CYCLES-1
               if (wdog_inc_c == WDOG_W'(WDOG_CYCLES - 1)) begin
                  state_d  = ST_FINISH;
                  rdata_d  = 16'hFFFF;
                  err_d    = 1'b1;
                  done_a_d = gnt_a_q;
                  done_b_d = gnt_b_q;
               end
            end
`endif
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous reset
   always_ff @(posedge OSC_50) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         gnt_a_q   <= 1'b0;
         gnt_b_q   <= 1'b0;
         done_a_q  <= 1'b0;
         done_b_q  <= 1'b0;
         m_start_q <= 1'b0;
         m_cmd_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         last_b_q  <= 1'b1;
`ifdef I2C_ARB_WDOG_EN
         wdog_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_a_q   <= gnt_a_d;
         gnt_b_q   <= gnt_b_d;
         done_a_q  <= done_a_d;
         done_b_q  <= done_b_d;
         m_start_q <= m_start_d;
         m_cmd_q   <= m_cmd_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         last_b_q  <= last_b_d;
`ifdef I2C_ARB_WDOG_EN
         wdog_q    <= wdog_d;
`endif
      end
   end

   assign GNT_A   = gnt_a_q;
   assign GNT_B   = gnt_b_q;
   assign DONE_A  = done_a_q;
   assign DONE_B  = done_b_q;
   assign RDATA   = rdata_q;
   assign ERR     = err_q;
   assign M_START = m_start_q;
   assign M_CMD   = m_cmd_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
// Directed self-checking bench for i2c_bus_arbiter. Inputs are driven and
// outputs sampled on the falling edge of OSC_50; the master side is played
// by the bench tasks. Watchdog checks follow I2C_ARB_WDOG_EN.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

   localparam int unsigned WDOG = 100;

   logic        OSC_50  = 1'b0;
   logic        RESET_N = 1'b0;
   logic        REQ_A   = 1'b0;
   logic [31:0] CMD_A   = '0;
   logic        REQ_B   = 1'b0;
   logic [31:0] CMD_B   = '0;
   logic        GNT_A, GNT_B, DONE_A, DONE_B, ERR, M_START;
   logic [15:0] RDATA;
   logic [31:0] M_CMD;
   logic        M_BUSY  = 1'b0;
   logic        M_DONE  = 1'b0;
   logic [15:0] M_RDATA = '0;
   logic        M_NACK  = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   i2c_bus_arbiter #(.WDOG_CYCLES(WDOG)) dut (
      .OSC_50  (OSC_50),
      .RESET_N (RESET_N),
      .REQ_A   (REQ_A),
      .CMD_A   (CMD_A),
      .REQ_B   (REQ_B),
      .CMD_B   (CMD_B),
      .GNT_A   (GNT_A),
      .GNT_B   (GNT_B),
      .DONE_A  (DONE_A),
      .DONE_B  (DONE_B),
      .RDATA   (RDATA),
      .ERR     (ERR),
      .M_START (M_START),
      .M_CMD   (M_CMD),
      .M_BUSY  (M_BUSY),
      .M_DONE  (M_DONE),
      .M_RDATA (M_RDATA),
      .M_NACK  (M_NACK)
   );

   always #10 OSC_50 = ~OSC_50;

   task automatic tick();
      @(negedge OSC_50);
   endtask

   task automatic apply_reset();
      RESET_N = 1'b0;
      REQ_A = 1'b0; REQ_B = 1'b0;
      M_BUSY = 1'b0; M_DONE = 1'b0; M_NACK = 1'b0; M_RDATA = '0;
      repeat (2) tick();
      RESET_N = 1'b1;
   endtask

   // Reset values while requests and a stray M_DONE are active
   task automatic test_reset();
      RESET_N = 1'b0;
      REQ_A = 1'b1; REQ_B = 1'b1; M_DONE = 1'b1; M_RDATA = 16'h5A5A;
      CMD_A = 32'h1111_1111; CMD_B = 32'h2222_2222;
      repeat (3) tick();
      n_vec++; if (GNT_A !== 1'b0 || GNT_B !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b%b expected 00", GNT_A, GNT_B); end
      n_vec++; if (DONE_A !== 1'b0 || DONE_B !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b%b expected 00", DONE_A, DONE_B); end
      n_vec++; if (M_START !== 1'b0) begin n_err++; $display("FAIL reset_mstart: got %b expected 0", M_START); end
      n_vec++; if (M_CMD !== 32'h0) begin n_err++; $display("FAIL reset_mcmd: got %h expected 00000000", M_CMD); end
      n_vec++; if (RDATA !== 16'h0 || ERR !== 1'b0) begin n_err++; $display("FAIL reset_rdata_err: got %h/%b expected 0000/0", RDATA, ERR); end
      REQ_A = 1'b0; REQ_B = 1'b0; M_DONE = 1'b0;
      RESET_N = 1'b1;
      tick();
   endtask

   // Single read on A with the master idle
   task automatic test_single_read();
      apply_reset();
      REQ_A = 1'b1; CMD_A = 32'h4C0A_0000;
      tick();
      n_vec++; if (M_START !== 1'b1) begin n_err++; $display("FAIL single_start_latency: got %b expected 1", M_START); end
      n_vec++; if (GNT_A !== 1'b1 || GNT_B !== 1'b0) begin n_err++; $display("FAIL single_gnt: got %b%b expected 10", GNT_A, GNT_B); end
      n_vec++; if (M_CMD !== 32'h4C0A_0000) begin n_err++; $display("FAIL single_mcmd: got %h expected 4c0a0000", M_CMD); end
      REQ_A = 1'b0;
      tick();
      n_vec++; if (M_START !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b expected 0", M_START); end
      M_DONE = 1'b1; M_RDATA = 16'h0025; M_NACK = 1'b0;
      tick();
      M_DONE = 1'b0;
      n_vec++; if (DONE_A !== 1'b1 || DONE_B !== 1'b0) begin n_err++; $display("FAIL single_done: got %b%b expected 10", DONE_A, DONE_B); end
      n_vec++; if (RDATA !== 16'h0025 || ERR !== 1'b0) begin n_err++; $display("FAIL single_rdata: got %h/%b expected 0025/0", RDATA, ERR); end
      n_vec++; if (GNT_A !== 1'b1) begin n_err++; $display("FAIL single_gnt_finish: got %b expected 1", GNT_A); end
      tick();
      n_vec++; if (GNT_A !== 1'b0 || DONE_A !== 1'b0) begin n_err++; $display("FAIL single_release: got gnt %b done %b expected 0 0", GNT_A, DONE_A); end
   endtask

   // Both requests held from reset: A, B, A, B with an idle cycle between
   task automatic test_round_robin();
      logic exp_b;
      RESET_N = 1'b0;
      REQ_A = 1'b1; REQ_B = 1'b1;
      CMD_A = 32'hAAAA_0001; CMD_B = 32'hBBBB_0002;
      repeat (2) tick();
      RESET_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_b = (i % 2) == 1;
         tick();
         n_vec++; if (M_START !== 1'b1 || GNT_A !== !exp_b || GNT_B !== exp_b) begin n_err++; $display("FAIL rr_grant_%0d: got start %b gnt %b%b expected start 1 gnt %b%b", i, M_START, GNT_A, GNT_B, !exp_b, exp_b); end
         n_vec++; if (M_CMD !== (exp_b ? 32'hBBBB_0002 : 32'hAAAA_0001)) begin n_err++; $display("FAIL rr_mcmd_%0d: got %h expected %h", i, M_CMD, exp_b ? 32'hBBBB_0002 : 32'hAAAA_0001); end
         tick();
         M_DONE = 1'b1; M_RDATA = 16'h0100 + 16'(i); M_NACK = 1'b0;
         tick();
         M_DONE = 1'b0;
         n_vec++; if (DONE_A !== !exp_b || DONE_B !== exp_b || RDATA !== 16'h0100 + 16'(i)) begin n_err++; $display("FAIL rr_done_%0d: got done %b%b rdata %h expected %b%b %h", i, DONE_A, DONE_B, RDATA, !exp_b, exp_b, 16'h0100 + 16'(i)); end
         tick();
         n_vec++; if (GNT_A !== 1'b0 || GNT_B !== 1'b0 || DONE_A !== 1'b0 || DONE_B !== 1'b0 || M_START !== 1'b0) begin n_err++; $display("FAIL rr_idle_%0d: got gnt %b%b done %b%b start %b expected all 0", i, GNT_A, GNT_B, DONE_A, DONE_B, M_START); end
         if (i == 3) begin
            REQ_A = 1'b0; REQ_B = 1'b0;
         end
      end
      tick();
      n_vec++; if (GNT_A !== 1'b0 || GNT_B !== 1'b0) begin n_err++; $display("FAIL rr_quiet: got gnt %b%b expected 00", GNT_A, GNT_B); end
   endtask

   // NACK on B, then a clean transaction on A
   task automatic test_nack();
      apply_reset();
      REQ_B = 1'b1; CMD_B = 32'h2A05_0000;
      tick();
      n_vec++; if (GNT_B !== 1'b1 || GNT_A !== 1'b0 || M_CMD !== 32'h2A05_0000) begin n_err++; $display("FAIL nack_gnt_b: got gnt %b%b cmd %h expected 01 2a050000", GNT_A, GNT_B, M_CMD); end
      REQ_B = 1'b0;
      tick();
      M_DONE = 1'b1; M_NACK = 1'b1; M_RDATA = 16'h00EE;
      tick();
      M_DONE = 1'b0; M_NACK = 1'b0;
      n_vec++; if (DONE_B !== 1'b1 || ERR !== 1'b1) begin n_err++; $display("FAIL nack_err: got done_b %b err %b expected 1 1", DONE_B, ERR); end
      tick();
      REQ_A = 1'b1; CMD_A = 32'h4C0B_0000;
      tick();
      n_vec++; if (GNT_A !== 1'b1 || M_CMD !== 32'h4C0B_0000) begin n_err++; $display("FAIL nack_gnt_a: got gnt_a %b cmd %h expected 1 4c0b0000", GNT_A, M_CMD); end
      REQ_A = 1'b0;
      tick();
      M_DONE = 1'b1; M_NACK = 1'b0; M_RDATA = 16'h1357;
      tick();
      M_DONE = 1'b0;
      n_vec++; if (DONE_A !== 1'b1 || ERR !== 1'b0 || RDATA !== 16'h1357) begin n_err++; $display("FAIL nack_clear: got done_a %b err %b rdata %h expected 1 0 1357", DONE_A, ERR, RDATA); end
      tick();
   endtask

   // Master never completes
   task automatic test_watchdog();
      int  k;
      int  bad;
      apply_reset();
      REQ_A = 1'b1; CMD_A = 32'h4C0C_0000;
      tick();
      n_vec++; if (M_START !== 1'b1) begin n_err++; $display("FAIL wdog_start: got %b expected 1", M_START); end
      REQ_A = 1'b0;
`ifdef I2C_ARB_WDOG_EN
      k = 0;
      for (int c = 1; c <= 2 * WDOG && k == 0; c++) begin
         tick();
         if (DONE_A === 1'b1) k = c;
      end
      n_vec++; if (k != WDOG) begin n_err++; $display("FAIL wdog_timeout_cycle: got %0d expected %0d", k, WDOG); end
      n_vec++; if (ERR !== 1'b1 || RDATA !== 16'hFFFF || GNT_A !== 1'b1) begin n_err++; $display("FAIL wdog_result: got err %b rdata %h gnt %b expected 1 ffff 1", ERR, RDATA, GNT_A); end
      tick();
      n_vec++; if (GNT_A !== 1'b0 || DONE_A !== 1'b0) begin n_err++; $display("FAIL wdog_release: got gnt %b done %b expected 0 0", GNT_A, DONE_A); end
`else
      bad = 0;
      for (int c = 1; c <= 3 * WDOG; c++) begin
         tick();
         if (GNT_A !== 1'b1 || DONE_A !== 1'b0) bad++;
      end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL wdog_off_hold: got %0d cycles without grant expected 0", bad); end
      M_DONE = 1'b1; M_RDATA = 16'h0042; M_NACK = 1'b0;
      tick();
      M_DONE = 1'b0;
      n_vec++; if (DONE_A !== 1'b1 || RDATA !== 16'h0042 || ERR !== 1'b0) begin n_err++; $display("FAIL wdog_off_done: got done %b rdata %h err %b expected 1 0042 0", DONE_A, RDATA, ERR); end
      tick();
`endif
   endtask

   // Reset during WAIT followed by a late M_DONE
   task automatic test_reset_in_wait();
      apply_reset();
      REQ_A = 1'b1; CMD_A = 32'h4C0D_0000;
      tick();
      REQ_A = 1'b0;
      repeat (2) tick();
      RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      M_DONE = 1'b1; M_RDATA = 16'hABCD; M_NACK = 1'b1;
      tick();
      M_DONE = 1'b0; M_NACK = 1'b0;
      n_vec++; if (DONE_A !== 1'b0 || DONE_B !== 1'b0) begin n_err++; $display("FAIL rstwait_done: got %b%b expected 00", DONE_A, DONE_B); end
      n_vec++; if (GNT_A !== 1'b0 || M_START !== 1'b0 || M_CMD !== 32'h0 || RDATA !== 16'h0 || ERR !== 1'b0) begin n_err++; $display("FAIL rstwait_outputs: got gnt %b start %b cmd %h rdata %h err %b expected 0 0 0 0 0", GNT_A, M_START, M_CMD, RDATA, ERR); end
      REQ_A = 1'b1; CMD_A = 32'h4C0E_0000;
      tick();
      REQ_A = 1'b0;
      n_vec++; if (M_START !== 1'b1 || GNT_A !== 1'b1 || M_CMD !== 32'h4C0E_0000) begin n_err++; $display("FAIL rstwait_next: got start %b gnt %b cmd %h expected 1 1 4c0e0000", M_START, GNT_A, M_CMD); end
      tick();
      M_DONE = 1'b1; M_RDATA = 16'h0077;
      tick();
      M_DONE = 1'b0;
      n_vec++; if (DONE_A !== 1'b1 || RDATA !== 16'h0077) begin n_err++; $display("FAIL rstwait_next_done: got done %b rdata %h expected 1 0077", DONE_A, RDATA); end
      tick();
   endtask

   // Busy master delays the start; stray M_DONE in ISSUE and CMD changes ignored
   task automatic test_busy_and_cmd_hold();
      apply_reset();
      M_BUSY = 1'b1;
      REQ_A = 1'b1; CMD_A = 32'h4C0F_0000;
      tick();
      n_vec++; if (GNT_A !== 1'b1 || M_START !== 1'b0) begin n_err++; $display("FAIL busy_hold: got gnt %b start %b expected 1 0", GNT_A, M_START); end
      M_DONE = 1'b1; M_RDATA = 16'hDEAD;
      tick();
      M_DONE = 1'b0;
      n_vec++; if (M_START !== 1'b0 || DONE_A !== 1'b0) begin n_err++; $display("FAIL busy_stray_done: got start %b done %b expected 0 0", M_START, DONE_A); end
      M_BUSY = 1'b0;
      tick();
      n_vec++; if (M_START !== 1'b1) begin n_err++; $display("FAIL busy_release_start: got %b expected 1", M_START); end
      tick();
      CMD_A = 32'h1234_5678; REQ_A = 1'b0; REQ_B = 1'b1; CMD_B = 32'h8765_4321;
      tick();
      n_vec++; if (M_CMD !== 32'h4C0F_0000 || GNT_A !== 1'b1 || GNT_B !== 1'b0 || M_START !== 1'b0) begin n_err++; $display("FAIL busy_cmd_hold: got cmd %h gnt %b%b start %b expected 4c0f0000 10 0", M_CMD, GNT_A, GNT_B, M_START); end
      REQ_B = 1'b0;
      M_DONE = 1'b1; M_RDATA = 16'h0099;
      tick();
      M_DONE = 1'b0;
      n_vec++; if (DONE_A !== 1'b1 || RDATA !== 16'h0099) begin n_err++; $display("FAIL busy_done: got done %b rdata %h expected 1 0099", DONE_A, RDATA); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_nack();
      test_watchdog();
      test_reset_in_wait();
      test_busy_and_cmd_hold();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL sim_timeout: got no completion expected finish within 1ms");
      $fatal(1, "simulation time limit");
   end

endmodule
